apb_cmd_master: RTL and testbench

//  APB requester: converts valid/ready commands from a CPU/debug-side client into APB3 transfers

---
 rtl/apb_cmd_master.sv | 136 +++++++++++++
 tb/tb_apb_cmd_master.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_cmd_master
// Brief    : Valid/ready command to APB3 requester with a single transfer in
//            flight, a registered response channel and an ACCESS watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module apb_cmd_master #(
    parameter int W_ADDR  = 16,
    parameter int W_DATA  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    // command channel
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [W_ADDR-1:0] cmd_addr,
    input  logic [W_DATA-1:0] cmd_wdata,
    // response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W_DATA-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    // APB3 requester
    output logic              apbm_psel,
    output logic              apbm_penable,
    output logic              apbm_pwrite,
    output logic [W_ADDR-1:0] apbm_paddr,
    output logic [W_DATA-1:0] apbm_pwdata,
    input  logic [W_DATA-1:0] apbm_prdata,
    input  logic              apbm_pready,
    input  logic              apbm_pslverr
);

    // A one-bit counter is kept when the watchdog is disabled so the width is never zero.
    localparam int c_CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = (TIMEOUT > 0) ? c_CW'(TIMEOUT - 1) : c_CW'(0);
    localparam logic [c_CW-1:0] c_CNT_MAX  = {c_CW{1'b1}};
    localparam logic            c_WDOG_ON  = (TIMEOUT > 0);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETUP  = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;
    localparam logic [1:0] c_RESP   = 2'd3;

    logic [1:0]        r_state;
    logic [c_CW-1:0]   r_cnt;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [W_ADDR-1:0] r_paddr;
    logic [W_DATA-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [W_DATA-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_rsp_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_cnt         <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (cmd_valid) begin
                        r_pwrite  <= cmd_write;
                        r_paddr   <= cmd_addr;
                        r_pwdata  <= cmd_wdata;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_state   <= c_SETUP;
                    end
                end
                c_SETUP: begin
                    r_penable <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= c_ACCESS;
                end
                c_ACCESS: begin
                    // pready on the watchdog edge still completes normally
                    if (apbm_pready) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_rdata   <= r_pwrite ? '0 : apbm_prdata;
                        r_rsp_err     <= apbm_pslverr;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= c_RESP;
                    end else if (c_WDOG_ON && (r_cnt == c_CNT_LAST)) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= c_RESP;
                    end else if (r_cnt != c_CNT_MAX) begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                c_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign cmd_ready    = (r_state == c_IDLE) & ~rst;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_err      = r_rsp_err;
    assign rsp_timeout  = r_rsp_timeout;
    assign apbm_psel    = r_psel;
    assign apbm_penable = r_penable;
    assign apbm_pwrite  = r_pwrite;
    assign apbm_paddr   = r_paddr;
    assign apbm_pwdata  = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_cmd_master
// Brief    : Directed vector bench for apb_cmd_master (TIMEOUT=8 and TIMEOUT=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_cmd_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // DUT with an 8-cycle watchdog
    logic        cmd_valid = 0, cmd_write = 0, rsp_ready = 0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0, prdata = '0;
    logic        pready = 0, pslverr = 0;
    logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata, pwdata;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;

    apb_cmd_master #(.W_ADDR(16), .W_DATA(32), .TIMEOUT(8)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .apbm_psel(psel), .apbm_penable(penable), .apbm_pwrite(pwrite),
        .apbm_paddr(paddr), .apbm_pwdata(pwdata), .apbm_prdata(prdata),
        .apbm_pready(pready), .apbm_pslverr(pslverr)
    );

    // DUT with the watchdog disabled
    logic        cmd_valid2 = 0, rsp_ready2 = 0, pready2 = 0;
    logic        cmd_ready2, rsp_valid2, rsp_err2, rsp_timeout2;
    logic [31:0] rsp_rdata2, pwdata2;
    logic        psel2, penable2, pwrite2;
    logic [15:0] paddr2;

    apb_cmd_master #(.W_ADDR(16), .W_DATA(32), .TIMEOUT(0)) u_dut_nowdog (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_write(1'b0),
        .cmd_addr(16'h0050), .cmd_wdata(32'h0),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_rdata(rsp_rdata2),
        .rsp_err(rsp_err2), .rsp_timeout(rsp_timeout2),
        .apbm_psel(psel2), .apbm_penable(penable2), .apbm_pwrite(pwrite2),
        .apbm_paddr(paddr2), .apbm_pwdata(pwdata2), .apbm_prdata(32'h7777_8888),
        .apbm_pready(pready2), .apbm_pslverr(1'b0)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        logic        slverr;
        int          wait_n;      // ACCESS cycles with pready=0 before pready=1
        int          hold;        // cycles rsp_ready is held low
        int          exp_access;  // ACCESS cycles (penable high)
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        int n;
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
        tick();
        // changes after the handshake must not reach the bus
        cmd_valid = 0; cmd_write = ~v.wr; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata;
        check("setup_psel_pen", {62'd0, psel, penable}, 64'b10);
        check("setup_cmd_ready", 64'(cmd_ready), 64'd0);
        check("setup_bus", {15'd0, pwrite, paddr, pwdata}, {15'd0, v.wr, v.addr, v.wdata});
        tick();
        n = 0;
        while (psel && n < 50) begin
            if (!penable || paddr !== v.addr || pwdata !== v.wdata || pwrite !== v.wr)
                check("access_bus_stable", {15'd0, penable, pwrite, paddr, pwdata},
                      {15'd1, v.wr, v.addr, v.wdata});
            pready = (n >= v.wait_n); pslverr = v.slverr; prdata = v.prdata;
            tick();
            n++;
        end
        pready = 0; pslverr = 0;
        check("access_cycles", 64'(n), 64'(v.exp_access));
        check("done_penable", 64'(penable), 64'd0);
        for (int h = 0; h <= v.hold; h++) begin
            if (h == v.hold) rsp_ready = 1;
            check("rsp_fields", {28'd0, rsp_valid, rsp_err, rsp_timeout, cmd_ready, rsp_rdata},
                  {28'd0, 1'b1, v.exp_err, v.exp_to, 1'b0, v.exp_rdata});
            check("rsp_bus_idle", {62'd0, psel, penable}, 64'd0);
            tick();
        end
        rsp_ready = 0;
        check("after_rsp", {62'd0, rsp_valid, cmd_ready}, 64'b01);
    endtask

    initial begin
        vecs[0] = '{1'b0, 16'h0010, 32'h0,          32'hA5A5_0001, 1'b0, 0,  0, 1, 32'hA5A5_0001, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'h0004, 32'h0000_00FF, 32'hDEAD_BEEF, 1'b0, 3,  0, 4, 32'h0,         1'b0, 1'b0};
        vecs[2] = '{1'b1, 16'h0008, 32'h1234_5678, 32'h5555_AAAA, 1'b1, 1,  0, 2, 32'h0,         1'b1, 1'b0};
        vecs[3] = '{1'b0, 16'h0020, 32'h0,          32'hCAFE_F00D, 1'b0, 99, 2, 8, 32'h0,         1'b1, 1'b1};
        vecs[4] = '{1'b0, 16'h0030, 32'h0,          32'h1111_2222, 1'b0, 7,  0, 8, 32'h1111_2222, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 16'h0040, 32'h0,          32'h0BAD_0BAD, 1'b1, 0,  5, 1, 32'h0BAD_0BAD, 1'b1, 1'b0};

        // reset state
        cmd_valid = 1;
        tick(); tick();
        check("reset_outputs", {52'd0, psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout,
                                cmd_ready, 5'd0}, 64'd0);
        check("reset_bus_data", {16'd0, paddr, pwdata}, 64'd0);
        check("reset_rdata", 64'(rsp_rdata), 64'd0);
        cmd_valid = 0;
        rst = 0;
        #1;
        check("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // reset in the middle of ACCESS
        cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0060; cmd_wdata = 32'h600D_600D;
        tick();
        cmd_valid = 0;
        tick(); tick();
        check("pre_rst_access", {62'd0, psel, penable}, 64'b11);
        rst = 1;
        tick();
        check("rst_mid_xfer", {60'd0, psel, penable, rsp_valid, cmd_ready}, 64'd0);
        rst = 0;
        #1;
        check("cmd_ready_post_rst", 64'(cmd_ready), 64'd1);
        run_vec(vecs[0]);

        // watchdog disabled: the slave may stall indefinitely
        cmd_valid2 = 1;
        tick();
        cmd_valid2 = 0;
        repeat (1001) tick();
        check("nowdog_waiting", {61'd0, psel2, penable2, rsp_valid2}, 64'b110);
        pready2 = 1;
        tick();
        pready2 = 0;
        check("nowdog_complete", {29'd0, rsp_valid2, rsp_err2, rsp_timeout2, rsp_rdata2},
              {29'd0, 3'b100, 32'h7777_8888});
        rsp_ready2 = 1;
        tick();
        rsp_ready2 = 0;
        check("nowdog_idle", {62'd0, rsp_valid2, cmd_ready2}, 64'b01);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
